qpu_time_trigger: RTL and testbench
===================================

# qpu_time_trigger

Timeline master at the consumer end of the execution-unit time/event queue. Owns the global timestamp counter presented to the queue, drives the queue's trigger input, and advances time only when the queue grants the clock enable. It captures the per-channel event valid/data the queue releases at each matching timestamp and re-issues them as registered one-cycle pulses to the qubit/measure channel drivers. It also runs a stall watchdog for the case where the program stops supplying timestamps.

## Interface
Parameters:
- `TIME_WIDTH`, 16: timestamp width; equals `QPU_TIME_WIDTH`.
- `EVENT_NUM`, 10: event channel count; equals `QPU_EVENT_NUM`.
- `EVENT_WIRE_WIDTH`, 64: concatenated event data width; equals `QPU_EVENT_WIRE_WIDTH`.
- `STALL_LIMIT`, 1024: consecutive stalled cycles before the error state; minimum 2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begin the timeline from time 0.
- `stop` in 1: one-cycle pulse; abort or finish the timeline. Has priority over `start`.
- `trigger_o_clk` out TIME_WIDTH: current timestamp, registered, to the queue.
- `i_trigger` out 1: timeline active, registered, to the queue.
- `trigger_o_clk_ena` in 1: time-advance grant from the queue.
- `evq_dest_o_valid` in EVENT_NUM: per-channel event released by the queue this cycle.
- `evq_dest_o_data` in EVENT_WIRE_WIDTH: event payload from the queue.
- `evt_o_valid` out EVENT_NUM: registered per-channel event pulse.
- `evt_o_data` out EVENT_WIRE_WIDTH: registered payload.
- `evt_o_time` out TIME_WIDTH: timestamp at which the current `evt_o_*` was released.
- `busy` out 1: state is RUN or STALL.
- `stall_err` out 1: sticky watchdog error.
- `wrap` out 1: sticky flag; the timestamp wrapped past all-ones.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - STALL.
  - ERROR.
- Transitions:
  - IDLE → RUN on `start & ~stop`.
  - RUN → STALL when `~trigger_o_clk_ena`.
  - STALL → RUN when `trigger_o_clk_ena`.
  - STALL → ERROR when the stall count reaches `STALL_LIMIT-1` with the enable still low.
  - RUN, STALL or ERROR → IDLE on `stop`.
  - ERROR → RUN on `start & ~stop`.
  - `start` in RUN or STALL is ignored.
- Entering RUN from IDLE or ERROR:
  - Timestamp cleared to 0.
  - `wrap`, `stall_err` and the stall counter cleared.
- `i_trigger` = 1 exactly in RUN and STALL. The output is registered and reflects the state.
- Timestamp increments by 1, modulo 2^TIME_WIDTH, on every cycle where `i_trigger & trigger_o_clk_ena`; otherwise it holds.
  - Increment from all-ones gives 0 and sets `wrap`.
  - In IDLE and ERROR the timestamp holds its last value for readback.
- Stall counter:
  - Counts cycles where `i_trigger & ~trigger_o_clk_ena`.
  - Clears on any cycle where the enable is granted.
  - Saturates; it never wraps.
- ERROR sets `stall_err`. `stall_err` clears only on the next `start` or on `stop`.
- Event capture, on every cycle with `i_trigger = 1`:
  - `evt_o_valid` ← `evq_dest_o_valid`.
  - If any input valid: `evt_o_data` ← `evq_dest_o_data` and `evt_o_time` ← current `trigger_o_clk`.
  - If no input valid: data and time hold.
- When `i_trigger = 0`, `evt_o_valid` ← 0 and the inputs are ignored.
- `busy` is high exactly when `i_trigger` is high.

## Timing
- Reset values of all outputs:
  - `trigger_o_clk` = 0.
  - `i_trigger` = 0.
  - `evt_o_valid` = 0.
  - `evt_o_data` = 0.
  - `evt_o_time` = 0.
  - `busy` = 0.
  - `stall_err` = 0.
  - `wrap` = 0.
- `start` sampled at edge N → at edge N+1: `i_trigger` = 1 and `trigger_o_clk` = 0.
- Queue release at timestamp T (cycle with `trigger_o_clk` = T) → `evt_o_valid` asserted for exactly the next cycle, with `evt_o_time` = T. Latency is 1 cycle.
- The queue computes `trigger_o_clk_ena` combinationally from `i_trigger` and `trigger_o_clk`. This block samples it only at the clock edge and must not feed it back combinationally into any output.
- `stop` at edge N → `i_trigger` = 0 from edge N+1.
  - An event valid present in cycle N is still captured and issued in cycle N+1.
  - Nothing is captured after that.
- Simultaneous `start` and `stop` in IDLE: stay in IDLE.
- `rst_n` low mid-timeline: all state and outputs return to their reset values immediately (asynchronously). No pulse is issued after reset.

## Test plan
- Reset, then `start`, with the enable held at 1 → `i_trigger` = 1 the next cycle; `trigger_o_clk` counts 0, 1, 2, …; `busy` = 1.
- Enable low for 3 cycles at T = 5 → timestamp holds at 5 for 3 cycles, then resumes 6; `stall_err` stays 0.
- Channel 2 valid with data 0xA5 in the cycle where T = 7 → next cycle `evt_o_valid` = 0x004, `evt_o_data` = 0xA5, `evt_o_time` = 7. The cycle after, `evt_o_valid` = 0.
- `STALL_LIMIT` = 4 with the enable held low from T = 3 → ERROR entered and `i_trigger` = 0, `stall_err` = 1, timestamp reads 3. A subsequent `start` clears `stall_err` and restarts from 0.
- `TIME_WIDTH` = 4 with the enable held high → timestamp runs 15 → 0 and `wrap` = 1; `wrap` stays set until the next `start`.
- `stop` and `start` pulsed together in RUN → IDLE next cycle; `i_trigger` = 0; a later `start` alone restarts from 0.

Source files
------------

// File: rtl/qpu_time_trigger.sv
// Timeline master for the execution-unit time/event queue: owns the timestamp,
// drives the queue trigger, re-issues released events and watches for stalls.
module qpu_time_trigger #(
  parameter int TIME_WIDTH       = 16,
  parameter int EVENT_NUM        = 10,
  parameter int EVENT_WIRE_WIDTH = 64,
  parameter int STALL_LIMIT      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  output logic [TIME_WIDTH-1:0]       trigger_o_clk,
  output logic                        i_trigger,
  input  logic                        trigger_o_clk_ena,
  input  logic [EVENT_NUM-1:0]        evq_dest_o_valid,
  input  logic [EVENT_WIRE_WIDTH-1:0] evq_dest_o_data,
  output logic [EVENT_NUM-1:0]        evt_o_valid,
  output logic [EVENT_WIRE_WIDTH-1:0] evt_o_data,
  output logic [TIME_WIDTH-1:0]       evt_o_time,
  output logic                        busy,
  output logic                        stall_err,
  output logic                        wrap
);

  localparam int STALL_W = $clog2(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic                        trig_q, trig_d;
  logic [TIME_WIDTH-1:0]       time_q, time_d;
  logic                        wrap_q, wrap_d;
  logic                        err_q, err_d;
  logic [STALL_W-1:0]          stall_q, stall_d;
  logic [EVENT_NUM-1:0]        valid_q, valid_d;
  logic [EVENT_WIRE_WIDTH-1:0] data_q, data_d;
  logic [TIME_WIDTH-1:0]       evtime_q, evtime_d;
  logic                        restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trig_q   <= 1'b0;
      time_q   <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      valid_q  <= '0;
      data_q   <= '0;
      evtime_q <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_d;
      time_q   <= time_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      evtime_q <= evtime_d;
    end
  end

  // stop always wins; start only matters when the timeline is not active
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERROR: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      RUN: begin
        if (stop)                    state_d = IDLE;
        else if (!trigger_o_clk_ena) state_d = STALL;
      end
      STALL: begin
        if (stop)                      state_d = IDLE;
        else if (trigger_o_clk_ena)    state_d = RUN;
        else if (stall_q == STALL_MAX) state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign restart = ((state_q == IDLE) || (state_q == ERROR)) && start && !stop;

  // Trigger is computed from the next state so that it leaves a flop directly
  always_comb begin
    trig_d   = (state_d == RUN) || (state_d == STALL);
    time_d   = time_q;
    wrap_d   = wrap_q;
    stall_d  = stall_q;
    err_d    = err_q;
    valid_d  = '0;
    data_d   = data_q;
    evtime_d = evtime_q;

    if (restart) begin
      time_d  = '0;
      wrap_d  = 1'b0;
      stall_d = '0;
    end else if (trig_q) begin
      if (trigger_o_clk_ena) begin
        time_d  = time_q + 1'b1;
        stall_d = '0;
        if (&time_q) wrap_d = 1'b1;
      end else if (stall_q != STALL_MAX) begin
        stall_d = stall_q + 1'b1;
      end
    end

    if (stop || restart)                        err_d = 1'b0;
    else if (state_q == STALL && state_d == ERROR) err_d = 1'b1;

    if (trig_q) begin
      valid_d = evq_dest_o_valid;
      if (|evq_dest_o_valid) begin
        data_d   = evq_dest_o_data;
        evtime_d = time_q;
      end
    end
  end

  assign trigger_o_clk = time_q;
  assign i_trigger     = trig_q;
  assign busy          = trig_q;
  assign stall_err     = err_q;
  assign wrap          = wrap_q;
  assign evt_o_valid   = valid_q;
  assign evt_o_data    = data_q;
  assign evt_o_time    = evtime_q;

endmodule

// File: tb/tb_qpu_time_trigger.sv
// Randomized bench for qpu_time_trigger against a timeline-level model,
// plus directed scenarios with literal expectations.
module tb_qpu_time_trigger;

  localparam int TW   = 4;
  localparam int EN   = 10;
  localparam int EWW  = 64;
  localparam int SL   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           ena = 1'b0;
  logic [EN-1:0]  evqValid = '0;
  logic [EWW-1:0] evqData = '0;
  logic [TW-1:0]  trigClk;
  logic           iTrigger;
  logic [EN-1:0]  evtValid;
  logic [EWW-1:0] evtData;
  logic [TW-1:0]  evtTime;
  logic           busy;
  logic           stallErr;
  logic           wrapFlag;

  int errors = 0;
  int checks = 0;
  bit checkOn = 1'b0;

  bit             mActive = 1'b0;
  bit             mErr = 1'b0;
  bit             mWrap = 1'b0;
  int             mTime = 0;
  int             mRun = 0;
  logic [EN-1:0]  mValid = '0;
  logic [EWW-1:0] mData = '0;
  int             mEvTime = 0;

  qpu_time_trigger #(
    .TIME_WIDTH(TW), .EVENT_NUM(EN), .EVENT_WIRE_WIDTH(EWW), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .trigger_o_clk(trigClk), .i_trigger(iTrigger), .trigger_o_clk_ena(ena),
    .evq_dest_o_valid(evqValid), .evq_dest_o_data(evqData),
    .evt_o_valid(evtValid), .evt_o_data(evtData), .evt_o_time(evtTime),
    .busy(busy), .stall_err(stallErr), .wrap(wrapFlag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [EWW-1:0] act, input logic [EWW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mErr = 0; mWrap = 0; mTime = 0; mRun = 0;
    mValid = '0; mData = '0; mEvTime = 0;
  endtask

  // A timeline is either active or not; the error flag marks a watchdog abort
  task automatic modelStep(input bit st, input bit sp, input bit en,
                           input logic [EN-1:0] v, input logic [EWW-1:0] d);
    if (mActive) begin
      mValid = v;
      if (v != '0) begin
        mData = d;
        mEvTime = mTime;
      end
      if (en) begin
        mRun = 0;
        if (mTime == TMAX) begin
          mTime = 0;
          mWrap = 1;
        end else mTime = mTime + 1;
      end else mRun = mRun + 1;
      if (sp) begin
        mActive = 0;
        mErr = 0;
      end else if (mRun >= SL) begin
        mActive = 0;
        mErr = 1;
      end
    end else begin
      mValid = '0;
      if (sp) mErr = 0;
      else if (st) begin
        mActive = 1; mTime = 0; mWrap = 0; mErr = 0; mRun = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at negedge
  task automatic applyStimulus(input bit st, input bit sp, input bit en,
                               input logic [EN-1:0] v, input logic [EWW-1:0] d);
    start = st; stop = sp; ena = en; evqValid = v; evqData = d;
    @(posedge clk);
    if (rst_n) modelStep(st, sp, en, v, d);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("i_trigger", 64'(iTrigger), 64'(mActive));
      checkOutput("busy", 64'(busy), 64'(mActive));
      checkOutput("stall_err", 64'(stallErr), 64'(mErr));
      checkOutput("wrap", 64'(wrapFlag), 64'(mWrap));
      checkOutput("trigger_o_clk", 64'(trigClk), 64'(mTime));
      checkOutput("evt_o_valid", 64'(evtValid), 64'(mValid));
      checkOutput("evt_o_data", evtData, mData);
      checkOutput("evt_o_time", 64'(evtTime), 64'(mEvTime));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkOn = 1'b1;
    checkOutput("reset trigger_o_clk", 64'(trigClk), 64'd0);
    checkOutput("reset i_trigger", 64'(iTrigger), 64'd0);
    checkOutput("reset evt_o_valid", 64'(evtValid), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1, 0, 1, '0, '0);
    checkOutput("start i_trigger", 64'(iTrigger), 64'd1);
    checkOutput("start time", 64'(trigClk), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, '0, '0);
    checkOutput("count to 5", 64'(trigClk), 64'd5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, '0, '0);
      checkOutput("stall hold", 64'(trigClk), 64'd5);
    end
    checkOutput("short stall no err", 64'(stallErr), 64'd0);
    applyStimulus(0, 0, 1, '0, '0);
    checkOutput("resume 6", 64'(trigClk), 64'd6);
    applyStimulus(0, 0, 1, '0, '0);
    applyStimulus(0, 0, 1, 10'h004, 64'hA5);
    checkOutput("event valid", 64'(evtValid), 64'h004);
    checkOutput("event data", evtData, 64'hA5);
    checkOutput("event time", 64'(evtTime), 64'd7);
    applyStimulus(0, 0, 1, '0, '0);
    checkOutput("event one pulse", 64'(evtValid), 64'd0);

    applyStimulus(0, 1, 1, '0, '0);
    applyStimulus(1, 0, 1, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, '0);
    checkOutput("stall still active", 64'(iTrigger), 64'd1);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("error i_trigger", 64'(iTrigger), 64'd0);
    checkOutput("error stall_err", 64'(stallErr), 64'd1);
    checkOutput("error time", 64'(trigClk), 64'd3);
    applyStimulus(1, 0, 1, '0, '0);
    checkOutput("restart clears err", 64'(stallErr), 64'd0);
    checkOutput("restart time", 64'(trigClk), 64'd0);

    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, '0, '0);
    checkOutput("time at max", 64'(trigClk), 64'd15);
    checkOutput("no wrap yet", 64'(wrapFlag), 64'd0);
    applyStimulus(0, 0, 1, '0, '0);
    checkOutput("wrapped time", 64'(trigClk), 64'd0);
    checkOutput("wrap set", 64'(wrapFlag), 64'd1);
    applyStimulus(1, 1, 1, '0, '0);
    checkOutput("start+stop in run", 64'(iTrigger), 64'd0);
    checkOutput("wrap sticky", 64'(wrapFlag), 64'd1);
    applyStimulus(1, 1, 1, '0, '0);
    checkOutput("start+stop in idle", 64'(iTrigger), 64'd0);
    applyStimulus(1, 0, 1, '0, '0);
    checkOutput("restart after stop", 64'(trigClk), 64'd0);
    checkOutput("wrap cleared", 64'(wrapFlag), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [EN-1:0]  v;
      logic [EWW-1:0] d;
      bit st, sp, en;
      st = ($urandom_range(0, 99) < 6);
      sp = ($urandom_range(0, 99) < 3);
      en = ($urandom_range(0, 99) < 75);
      v  = ($urandom_range(0, 99) < 35) ? EN'($urandom) : '0;
      d  = {$urandom, $urandom};
      if (i == 1500 || i == 3100) begin
        applyStimulus(1, 0, 1, 10'h3FF, d);
        #2 rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        applyStimulus(0, 0, 1, 10'h3FF, d);
        #2 rst_n = 1'b1;
        @(negedge clk);
      end else begin
        applyStimulus(st, sp, en, v, d);
      end
    end

    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
